rr_burst_scheduler: RTL and testbench

//  Shares one downstream valid/ready beat port among NumOfAgents requesters.

---
 rtl/rr_burst_scheduler_pkg.sv | 22 ++
 rtl/rr_burst_scheduler_pick.sv | 33 +++
 rtl/rr_burst_scheduler.sv | 111 +++++++++++
 tb/tb_rr_burst_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_burst_scheduler_pkg.sv
// Shared types and helpers for the round-robin burst scheduler.
package rr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } sched_state_e;

  // Upper bound on agent count supported by the helpers below.
  localparam int unsigned MAX_AGENTS = 32;

  // One-hot vector with bit idx set; callers size-cast to their agent count.
  function automatic logic [MAX_AGENTS-1:0] onehot(input int unsigned idx);
    return MAX_AGENTS'(1) << idx;
  endfunction

  // Next index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_burst_scheduler_pick.sv
// Round-robin pick: first requester after last_owner, wrapping around.
module rr_pick
  import rr_sched_pkg::*;
#(
  parameter  int unsigned NumOfAgents = 4,
  localparam int unsigned IdW         = $clog2(NumOfAgents)
) (
  input  logic [NumOfAgents-1:0] req,
  input  logic [IdW-1:0]         last_owner,
  output logic [IdW-1:0]         winner,
  output logic                   any
);

  logic [NumOfAgents-1:0] rotated;
  int unsigned            start;
  int unsigned            pos;

  // Rotate so the search origin sits at bit 0, take the lowest set bit, map back.
  always_comb begin
    rotated = '0;
    pos     = 0;
    start   = wrap_inc(32'(last_owner), NumOfAgents);
    for (int k = 0; k < int'(NumOfAgents); k++) begin
      rotated[k] = req[IdW'((start + k) % NumOfAgents)];
    end
    for (int k = int'(NumOfAgents) - 1; k >= 0; k--) begin
      if (rotated[k]) pos = k;
    end
    any    = |req;
    winner = IdW'((start + pos) % NumOfAgents);
  end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Shares one valid/ready beat port among several agents, round-robin, with a
// per-turn beat quantum. One arbitration cycle (bubble) between turns.
module rr_burst_scheduler
  import rr_sched_pkg::*;
#(
  parameter  int unsigned NumOfAgents = 4,
  parameter  int unsigned DataWidth   = 32,
  parameter  int unsigned MaxBurst    = 8,
  localparam int unsigned IdW         = $clog2(NumOfAgents),
  localparam int unsigned CntW        = (MaxBurst > 1) ? $clog2(MaxBurst) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NumOfAgents-1:0]           req_valid,
  input  logic [NumOfAgents*DataWidth-1:0] req_data,
  input  logic [NumOfAgents-1:0]           req_last,
  output logic [NumOfAgents-1:0]           req_ready,
  output logic                             out_valid,
  output logic [DataWidth-1:0]             out_data,
  output logic                             out_last,
  output logic [IdW-1:0]                   out_id,
  input  logic                             out_ready,
  output logic [NumOfAgents-1:0]           grant
);

  localparam logic [CntW-1:0] CNT_MAX = CntW'(MaxBurst - 1);

  sched_state_e           state_q, state_d;
  logic [NumOfAgents-1:0] grant_q, grant_d;
  logic [IdW-1:0]         own_q, own_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [IdW-1:0]         last_owner_q, last_owner_d;

  logic [IdW-1:0]         pick_winner;
  logic                   pick_any;
  logic                   xfer;

  rr_pick #(
    .NumOfAgents(NumOfAgents)
  ) u_pick (
    .req       (req_valid),
    .last_owner(last_owner_q),
    .winner    (pick_winner),
    .any       (pick_any)
  );

  // State, ownership and beat-count registers; last_owner resets so agent 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      own_q        <= '0;
      beat_cnt_q   <= '0;
      last_owner_q <= IdW'(NumOfAgents - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      own_q        <= own_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic plus the owner passthrough and ready demux.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    own_d        = own_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    req_ready    = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    xfer         = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = OWN;
          grant_d    = NumOfAgents'(onehot(32'(pick_winner)));
          own_d      = pick_winner;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        out_valid        = req_valid[own_q];
        out_data         = req_data[own_q*DataWidth +: DataWidth];
        out_last         = req_last[own_q];
        req_ready[own_q] = out_ready;
        xfer             = out_valid & out_ready;
        // A beat that is both last and quantum-final releases exactly once.
        if (xfer) begin
          if (out_last || (beat_cnt_q == CNT_MAX)) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = own_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_id = own_q;
  assign grant  = grant_q;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
module tb_rr_burst_scheduler;

  logic clk = 1'b0;
  logic rst;

  // Instance A: 4 agents, 32-bit data, quantum 8
  logic [3:0]   a_req_valid, a_req_last, a_req_ready, a_grant;
  logic [127:0] a_req_data;
  logic         a_out_valid, a_out_last, a_out_ready;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_id;

  // Instance B: 5 agents, 16-bit data, quantum 3
  logic [4:0]   b_req_valid, b_req_last, b_req_ready, b_grant;
  logic [79:0]  b_req_data;
  logic         b_out_valid, b_out_last, b_out_ready;
  logic [15:0]  b_out_data;
  logic [2:0]   b_out_id;

  int errors = 0;
  int checks = 0;

  initial forever #5 clk = ~clk;

  rr_burst_scheduler #(.NumOfAgents(4), .DataWidth(32), .MaxBurst(8)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_data(a_req_data), .req_last(a_req_last),
    .req_ready(a_req_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .out_id(a_out_id), .out_ready(a_out_ready), .grant(a_grant)
  );

  rr_burst_scheduler #(.NumOfAgents(5), .DataWidth(16), .MaxBurst(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_id(b_out_id), .out_ready(b_out_ready), .grant(b_grant)
  );

  task automatic clear_inputs();
    a_req_valid = '0; a_req_last = '0; a_req_data = '0; a_out_ready = 1'b0;
    b_req_valid = '0; b_req_last = '0; b_req_data = '0; b_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    a_req_valid = 4'b1111;
    a_req_last  = 4'b1111;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) a_req_data[i*32 +: 32] = 32'hA0 + i;
    @(posedge clk); #1;
    checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got=%b exp=0000", a_grant); end
    checks++; if (a_req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", a_req_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", a_out_data); end
    checks++; if ($isunknown(a_out_id)) begin errors++; $display("FAIL rst_out_id got=%b exp=known", a_out_id); end
    checks++; if (b_grant !== 5'b00000) begin errors++; $display("FAIL rst_b_grant got=%b exp=00000", b_grant); end
  endtask

  // All four valid with last=1: one beat per turn, grants 0,1,2,3,0 with bubbles.
  task automatic test_rr_order();
    logic [3:0] exp_g;
    int k;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      k = (i / 2) % 4;
      exp_g = (i % 2 == 0) ? 4'(1 << k) : 4'b0000;
      checks++; if (a_grant !== exp_g) begin errors++; $display("FAIL rr_grant step=%0d got=%b exp=%b", i, a_grant, exp_g); end
      if (i % 2 == 0) begin
        checks++; if (a_out_id !== 2'(k)) begin errors++; $display("FAIL rr_out_id step=%0d got=%0d exp=%0d", i, a_out_id, k); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hA0 + k) begin errors++; $display("FAIL rr_beat step=%0d got=%b/%h exp=1/%h", i, a_out_valid, a_out_data, 32'hA0 + k); end
        checks++; if (a_req_ready !== exp_g) begin errors++; $display("FAIL rr_req_ready step=%0d got=%b exp=%b", i, a_req_ready, exp_g); end
      end else begin
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) begin errors++; $display("FAIL rr_bubble step=%0d got=%b/%h exp=0/0", i, a_out_valid, a_out_data); end
      end
    end
  endtask

  // Agent 2 sends a 20-beat packet alone: turns of 8, 8, 4.
  task automatic test_quantum();
    int seq, turn_beats, nt;
    int turns[4];
    bit hs;
    do_reset();
    seq = 0; turn_beats = 0; nt = 0;
    a_out_ready = 1'b1;
    a_req_valid = 4'b0100;
    a_req_data[64 +: 32] = 32'h200;
    a_req_last[2] = 1'b0;
    for (int cyc = 0; cyc < 80 && seq < 20; cyc++) begin
      @(negedge clk);
      hs = a_out_valid && a_out_ready;
      if (hs) begin
        checks++; if (a_out_id !== 2'd2 || a_grant !== 4'b0100) begin errors++; $display("FAIL q_owner seq=%0d got=%0d/%b exp=2/0100", seq, a_out_id, a_grant); end
        checks++; if (a_out_data !== 32'h200 + seq) begin errors++; $display("FAIL q_data got=%h exp=%h", a_out_data, 32'h200 + seq); end
        checks++; if (a_out_last !== (seq == 19)) begin errors++; $display("FAIL q_last seq=%0d got=%b exp=%b", seq, a_out_last, seq == 19); end
        turn_beats++;
      end else if (a_grant == 4'b0000 && turn_beats > 0) begin
        if (nt < 4) turns[nt] = turn_beats;
        nt++; turn_beats = 0;
      end
      @(posedge clk); #1;
      if (hs) begin
        seq++;
        if (seq == 20) a_req_valid = 4'b0000;
        else begin
          a_req_data[64 +: 32] = 32'h200 + seq;
          a_req_last[2] = (seq == 19);
        end
      end
    end
    @(negedge clk);
    if (a_grant == 4'b0000 && turn_beats > 0) begin
      if (nt < 4) turns[nt] = turn_beats;
      nt++;
    end
    checks++; if (seq != 20) begin errors++; $display("FAIL q_timeout beats=%0d exp=20", seq); end
    checks++; if (nt != 3) begin errors++; $display("FAIL q_turns got=%0d exp=3", nt); end
    if (nt == 3) begin
      checks++; if (turns[0] != 8 || turns[1] != 8 || turns[2] != 4) begin errors++; $display("FAIL q_turn_len got=%0d,%0d,%0d exp=8,8,4", turns[0], turns[1], turns[2]); end
    end
  endtask

  // Agents 1 and 3, 6 beats each (last every 3rd), out_ready toggling.
  task automatic test_ready_toggle();
    int src_seq[4], exp_seq[4];
    int total, id;
    logic [3:0] hs_vec;
    do_reset();
    for (int i = 0; i < 4; i++) begin src_seq[i] = 0; exp_seq[i] = 0; end
    total = 0;
    a_out_ready = 1'b1;
    a_req_valid = 4'b1010;
    a_req_data[32 +: 32] = 32'h100;
    a_req_data[96 +: 32] = 32'h300;
    for (int cyc = 0; cyc < 200 && total < 12; cyc++) begin
      @(negedge clk);
      hs_vec = a_req_valid & a_req_ready;
      checks++; if ((a_req_ready & 4'b0101) != 0 || $countones(a_req_ready) > 1 || (!a_out_ready && a_req_ready != 0)) begin errors++; $display("FAIL tg_req_ready cyc=%0d got=%b ready=%b", cyc, a_req_ready, a_out_ready); end
      if (a_out_valid && a_out_ready) begin
        id = int'(a_out_id);
        checks++; if (hs_vec !== 4'(1 << id) || (id != 1 && id != 3)) begin errors++; $display("FAIL tg_id cyc=%0d got=%0d hs=%b", cyc, id, hs_vec); end
        else begin
          checks++; if (a_out_data !== 32'((id << 8) | exp_seq[id]) || a_out_last !== (exp_seq[id] % 3 == 2)) begin errors++; $display("FAIL tg_data id=%0d got=%h/%b exp=%h/%b", id, a_out_data, a_out_last, 32'((id << 8) | exp_seq[id]), exp_seq[id] % 3 == 2); end
          exp_seq[id]++;
        end
        total++;
      end
      @(posedge clk); #1;
      for (int i = 1; i < 4; i += 2) begin
        if (hs_vec[i]) begin
          src_seq[i]++;
          if (src_seq[i] == 6) a_req_valid[i] = 1'b0;
          else begin
            a_req_data[i*32 +: 32] = 32'((i << 8) | src_seq[i]);
            a_req_last[i] = (src_seq[i] % 3 == 2);
          end
        end
      end
      a_out_ready = ~a_out_ready;
    end
    checks++; if (exp_seq[1] != 6 || exp_seq[3] != 6 || total != 12) begin errors++; $display("FAIL tg_counts got=%0d,%0d,%0d exp=6,6,12", exp_seq[1], exp_seq[3], total); end
  endtask

  // Owner 0 stalls 5 cycles mid-turn while agent 1 waits.
  task automatic test_owner_stall();
    do_reset();
    a_out_ready = 1'b1;
    a_req_valid = 4'b0011;
    a_req_data[0 +: 32]  = 32'h0;
    a_req_data[32 +: 32] = 32'h100;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_grant !== 4'b0001 || a_out_data !== 32'h0) begin errors++; $display("FAIL st_first got=%b/%h exp=0001/0", a_grant, a_out_data); end
    @(posedge clk); #1;
    a_req_data[0 +: 32] = 32'h1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h1) begin errors++; $display("FAIL st_second got=%b/%h exp=1/1", a_out_valid, a_out_data); end
    @(posedge clk); #1;
    a_req_valid[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (a_grant !== 4'b0001 || a_out_valid !== 1'b0 || a_req_ready !== 4'b0001) begin errors++; $display("FAIL st_hold k=%0d got=%b/%b/%b exp=0001/0/0001", k, a_grant, a_out_valid, a_req_ready); end
      @(posedge clk);
    end
    #1;
    a_req_valid[0] = 1'b1;
    a_req_data[0 +: 32] = 32'h2;
    a_req_last[0] = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_last !== 1'b1 || a_out_data !== 32'h2) begin errors++; $display("FAIL st_resume got=%b/%b/%h exp=1/1/2", a_out_valid, a_out_last, a_out_data); end
    @(posedge clk); #1;
    a_req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL st_bubble got=%b exp=0000", a_grant); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_grant !== 4'b0010 || a_out_id !== 2'd1 || a_out_data !== 32'h100) begin errors++; $display("FAIL st_next got=%b/%0d/%h exp=0010/1/100", a_grant, a_out_id, a_out_data); end
  endtask

  // Reset asserted during agent 1's third beat; afterwards agent 0 wins first.
  task automatic test_async_reset();
    do_reset();
    a_out_ready = 1'b1;
    a_req_valid = 4'b0010;
    a_req_data[32 +: 32] = 32'h100;
    @(posedge clk);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h100 + b) begin errors++; $display("FAIL ar_beat b=%0d got=%b/%h exp=1/%h", b, a_out_valid, a_out_data, 32'h100 + b); end
      if (b < 2) begin
        @(posedge clk); #1;
        a_req_data[32 +: 32] = 32'h100 + b + 1;
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (a_grant !== 4'b0000 || a_req_ready !== 4'b0000 || a_out_valid !== 1'b0) begin errors++; $display("FAIL ar_drop got=%b/%b/%b exp=0000/0000/0", a_grant, a_req_ready, a_out_valid); end
    @(posedge clk);
    @(posedge clk);
    a_req_valid = 4'b0011;
    a_req_data[0 +: 32] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_grant !== 4'b0001 || a_out_id !== 2'd0 || a_out_valid !== 1'b1) begin errors++; $display("FAIL ar_after got=%b/%0d/%b exp=0001/0/1", a_grant, a_out_id, a_out_valid); end
  endtask

  // Random valid/ready/last on the 5-agent, quantum-3 instance with scoreboard.
  task automatic test_random();
    int src_seq[5], exp_seq[5], wcnt[5];
    bit src_last[5], wflag[5];
    int turn_beats, id, winner;
    bit expect_rel;
    logic [4:0] hs_vec, prev_grant;
    do_reset();
    turn_beats = 0; expect_rel = 1'b0; prev_grant = '0;
    for (int i = 0; i < 5; i++) begin
      src_seq[i] = 0; exp_seq[i] = 0; wcnt[i] = 0; wflag[i] = 1'b0;
      src_last[i] = ($urandom % 4 == 0);
      b_req_valid[i] = 1'($urandom % 2);
      b_req_last[i] = src_last[i];
      b_req_data[i*16 +: 16] = 16'((i << 12) | (src_seq[i] & 12'hfff));
    end
    b_out_ready = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      hs_vec = b_req_valid & b_req_ready;
      if (prev_grant == 5'b0 && b_grant != 5'b0) begin
        winner = int'(b_out_id);
        checks++; if (b_grant !== 5'(1 << winner)) begin errors++; $display("FAIL rnd_grant_onehot got=%b id=%0d", b_grant, winner); end
        for (int k = 0; k < 5; k++) begin
          if (k == winner) begin
            wflag[k] = 1'b0; wcnt[k] = 0;
          end else if (wflag[k]) begin
            wcnt[k]++;
            checks++; if (wcnt[k] > 4) begin errors++; $display("FAIL rnd_fair agent=%0d got=%0d turns exp<=4", k, wcnt[k]); end
          end
        end
        turn_beats = 0;
      end
      if (expect_rel) begin
        checks++; if (b_grant !== 5'b0) begin errors++; $display("FAIL rnd_release cyc=%0d got=%b exp=00000", cyc, b_grant); end
        expect_rel = 1'b0;
      end else if (prev_grant != 5'b0) begin
        checks++; if (b_grant !== prev_grant) begin errors++; $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", cyc, b_grant, prev_grant); end
      end
      if (b_out_valid && b_out_ready) begin
        id = int'(b_out_id);
        checks++; if (id > 4 || hs_vec !== 5'(1 << id)) begin errors++; $display("FAIL rnd_hs cyc=%0d id=%0d hs=%b", cyc, id, hs_vec); end
        else begin
          checks++; if (b_out_data !== 16'((id << 12) | (exp_seq[id] & 12'hfff)) || b_out_last !== src_last[id]) begin errors++; $display("FAIL rnd_data id=%0d got=%h/%b exp=%h/%b", id, b_out_data, b_out_last, 16'((id << 12) | (exp_seq[id] & 12'hfff)), src_last[id]); end
          exp_seq[id]++;
          turn_beats++;
          if (src_last[id] || turn_beats == 3) expect_rel = 1'b1;
        end
      end else begin
        checks++; if (hs_vec !== 5'b0) begin errors++; $display("FAIL rnd_spurious cyc=%0d hs=%b", cyc, hs_vec); end
      end
      for (int k = 0; k < 5; k++) if (b_req_valid[k] && !b_grant[k]) wflag[k] = 1'b1;
      prev_grant = b_grant;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
        if (hs_vec[k]) begin
          src_seq[k]++;
          src_last[k] = ($urandom % 4 == 0);
          b_req_valid[k] = 1'($urandom % 2);
        end else if (!b_req_valid[k]) begin
          b_req_valid[k] = 1'($urandom % 2);
        end
        b_req_last[k] = src_last[k];
        b_req_data[k*16 +: 16] = 16'((k << 12) | (src_seq[k] & 12'hfff));
      end
      b_out_ready = ($urandom % 4 != 0);
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (exp_seq[k] != src_seq[k] || exp_seq[k] == 0) begin errors++; $display("FAIL rnd_count agent=%0d got=%0d exp=%0d (nonzero)", k, exp_seq[k], src_seq[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_quantum();
    test_ready_toggle();
    test_owner_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
